// File: rtl/spi_master_if.sv
// SPI master bundle: byte-stream handshake towards the client plus the SPI bus pins.
interface spi_master_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCK;
    logic       MOSI;
    logic       SSEL;
    logic       MISO;

    modport master (
        input  tx_data, tx_last, tx_valid, MISO,
        output tx_ready, rx_data, rx_valid, busy, SCK, MOSI, SSEL
    );

    modport slave (
        output tx_data, tx_last, tx_valid, MISO,
        input  tx_ready, rx_data, rx_valid, busy, SCK, MOSI, SSEL
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 byte master with SSEL hold/gap framing.
// Define SPI_MASTER_LOOPBACK_EN to capture the internal MOSI instead of the MISO pin.
module spi_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, SHIFT, WAIT_NEXT, HOLD, GAP} state_e;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic       sck_q, sck_d;
    logic       last_q, last_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    logic tx_ready;
    logic div_end;
    logic accept;
    logic byte_end;
    logic sample_bit;

    assign div_end  = (div_q == DIV_LAST);
    assign accept   = bus.tx_valid && tx_ready;
    assign byte_end = (state_q == SHIFT) && div_end && sck_q && (bit_q == 3'd7);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = tx_sr_q[7];
`else
    assign sample_bit = bus.MISO;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            sck_q      <= 1'b0;
            last_q     <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            sck_q      <= sck_d;
            last_q     <= last_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WAIT_NEXT: if (accept) state_d = SHIFT;
            SHIFT:           if (byte_end) state_d = last_q ? HOLD : WAIT_NEXT;
            HOLD:            if (div_end) state_d = GAP;
            GAP:             if (div_end) state_d = IDLE;
            default:         state_d = IDLE;
        endcase
    end

    // Divider restarts at every SCK edge, so HOLD/GAP always begin at count 0.
    always_comb begin
        div_d      = div_q;
        bit_d      = bit_q;
        sck_d      = 1'b0;
        last_d     = last_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            SHIFT: begin
                sck_d = sck_q;
                if (div_end) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        rx_sr_d = {rx_sr_q[6:0], sample_bit};
                    end else begin
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        if (bit_q == 3'd7) begin
                            bit_d      = '0;
                            rx_data_d  = rx_sr_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            HOLD, GAP: div_d = div_end ? '0 : div_q + 8'd1;
            default: begin
                div_d = '0;
                bit_d = '0;
                if (accept) begin
                    tx_sr_d = bus.tx_data;
                    last_d  = bus.tx_last;
                end
            end
        endcase
    end

    always_comb begin
        tx_ready     = (state_q == IDLE) || (state_q == WAIT_NEXT);
        bus.tx_ready = tx_ready;
        bus.busy     = (state_q != IDLE);
        bus.SSEL     = (state_q == IDLE) || (state_q == GAP);
        bus.SCK      = sck_q;
        bus.MOSI     = (state_q == SHIFT) ? tx_sr_q[7] : 1'b0;
        bus.rx_data  = rx_data_q;
        bus.rx_valid = rx_valid_q;
    end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: scoreboarded byte vectors plus framing/reset corner sequences.
module tb_spi_master;
    localparam int unsigned CLK_DIV = 4;
`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    typedef struct {
        logic [7:0] tx;
        logic       last;
        logic [7:0] resp;
        logic [7:0] exp_rx;
    } vec_t;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] mosi;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    spi_master_if bus();

    spi_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    sb_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: byte n of resp_mem is shifted out MSB first, advancing on SCK rises.
    logic [7:0] resp_mem [0:63];
    int         w_idx = 0;
    int         slave_rises = 0;
    int         rise_adj = 0;
    logic       miso_force1 = 1'b0;
    int         eff;
    logic [7:0] cur_resp;

    always @(posedge bus.SCK) slave_rises <= slave_rises + 1;

    always_comb begin
        eff      = slave_rises - rise_adj;
        cur_resp = resp_mem[(eff / 8) % 64];
        bus.MISO = miso_force1 ? 1'b1 : cur_resp[7 - (eff % 8)];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_of(input logic [7:0] tx, input logic [7:0] resp);
        return LOOPBACK ? tx : resp;
    endfunction

    // Bus monitor
    logic mon_en = 1'b0;
    int sck_rise_cnt = 0, ssel_fall_cnt = 0, ssel_rise_cnt = 0, rx_cnt = 0;
    int rx_cyc = 0, ssel_rise_cyc = 0, last_gap = 0, mosi_viol = 0, rxv_wide = 0;
    logic [7:0] mosi_sr = '0;

    initial begin
        logic sck_prev, ssel_prev, rxv_prev;
        sb_t  e;
        sck_prev  = 1'b0;
        ssel_prev = 1'b1;
        rxv_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bus.SCK && !sck_prev) begin
                    sck_rise_cnt++;
                    mosi_sr = {mosi_sr[6:0], bus.MOSI};
                end
                if (bus.SSEL && !ssel_prev) begin
                    ssel_rise_cnt++;
                    ssel_rise_cyc = cyc;
                end
                if (!bus.SSEL && ssel_prev) begin
                    ssel_fall_cnt++;
                    last_gap = cyc - ssel_rise_cyc;
                end
                if (bus.SSEL && bus.MOSI !== 1'b0) mosi_viol++;
                if (bus.rx_valid && rxv_prev) rxv_wide++;
                if (bus.rx_valid) begin
                    rx_cnt++;
                    rx_cyc = cyc;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected: rx_data=%0h, required no rx_valid", bus.rx_data);
                    end else begin
                        e = sb_q.pop_front();
                        check("rx_data", {24'd0, bus.rx_data}, {24'd0, e.rx});
                        check("mosi_byte", {24'd0, mosi_sr}, {24'd0, e.mosi});
                    end
                end
                sck_prev  = bus.SCK;
                ssel_prev = bus.SSEL;
                rxv_prev  = bus.rx_valid;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic [7:0] resp,
                        input logic [7:0] exp_rx, input bit keep);
        int  n;
        sb_t e;
        resp_mem[w_idx % 64] = resp;
        w_idx++;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", bus.tx_ready, n);
            bus.tx_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        e.rx    = exp_rx;
        e.mosi  = d;
        sb_q.push_back(e);
        @(negedge clk);
        if (!keep) bus.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    vec_t vecs [6];

    initial begin
        int t0, r0, f0, u0, v0, nb, n, bad;

        vecs[0] = '{tx: 8'h03, last: 1'b0, resp: 8'hC3, exp_rx: exp_of(8'h03, 8'hC3)};
        vecs[1] = '{tx: 8'h11, last: 1'b0, resp: 8'h5A, exp_rx: exp_of(8'h11, 8'h5A)};
        vecs[2] = '{tx: 8'hFF, last: 1'b1, resp: 8'h00, exp_rx: exp_of(8'hFF, 8'h00)};
        vecs[3] = '{tx: 8'h80, last: 1'b1, resp: 8'hFF, exp_rx: exp_of(8'h80, 8'hFF)};
        vecs[4] = '{tx: 8'h01, last: 1'b0, resp: 8'h81, exp_rx: exp_of(8'h01, 8'h81)};
        vecs[5] = '{tx: 8'h7E, last: 1'b1, resp: 8'hE7, exp_rx: exp_of(8'h7E, 8'hE7)};

        for (int i = 0; i < 64; i++) resp_mem[i] = '0;
        rst_n        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.tx_last  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ssel", {31'd0, bus.SSEL}, 32'd1);
        check("rst_sck", {31'd0, bus.SCK}, 32'd0);
        check("rst_mosi", {31'd0, bus.MOSI}, 32'd0);
        check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        mon_en = 1'b1;

        // Single 0xA5 frame against slave byte 0x3C: latency of rx_valid and SSEL rise.
        send(8'hA5, 1'b1, 8'h3C, exp_of(8'hA5, 8'h3C), 1'b0);
        t0 = acc_cyc;
        wait_idle();
        check("rx_valid_latency", rx_cyc - t0, 1 + 16 * CLK_DIV);
        check("ssel_rise_latency", ssel_rise_cyc - t0, 1 + 17 * CLK_DIV);

        // Vector table; framing counts checked at each tx_last byte.
        nb = 0;
        r0 = sck_rise_cnt; f0 = ssel_fall_cnt; u0 = ssel_rise_cnt; v0 = rx_cnt;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].tx, vecs[i].last, vecs[i].resp, vecs[i].exp_rx, 1'b0);
            nb++;
            if (vecs[i].last) begin
                wait_idle();
                check("frame_sck_rises", sck_rise_cnt - r0, 8 * nb);
                check("frame_ssel_falls", ssel_fall_cnt - f0, 1);
                check("frame_ssel_rises", ssel_rise_cnt - u0, 1);
                check("frame_rx_pulses", rx_cnt - v0, nb);
                nb = 0;
                r0 = sck_rise_cnt; f0 = ssel_fall_cnt; u0 = ssel_rise_cnt; v0 = rx_cnt;
            end
        end

        // Stall 20 cycles in WAIT_NEXT.
        send(8'h42, 1'b0, 8'hB7, exp_of(8'h42, 8'hB7), 1'b0);
        n = 0;
        while (!bus.tx_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("wait_next_reached", {31'd0, bus.tx_ready}, 32'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.SCK !== 1'b0 || bus.SSEL !== 1'b0 || bus.tx_ready !== 1'b1) bad++;
        end
        check("wait_next_stable", bad, 0);
        send(8'h24, 1'b1, 8'hDB, exp_of(8'h24, 8'hDB), 1'b0);
        wait_idle();

        // Reset after the 4th SCK rise aborts the byte.
        r0 = sck_rise_cnt;
        send(8'h96, 1'b1, 8'h69, exp_of(8'h96, 8'h69), 1'b0);
        n = 0;
        while (sck_rise_cnt < r0 + 4 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_4th_rise", sck_rise_cnt - r0, 4);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ssel", {31'd0, bus.SSEL}, 32'd1);
        check("abort_sck", {31'd0, bus.SCK}, 32'd0);
        check("abort_mosi", {31'd0, bus.MOSI}, 32'd0);
        check("abort_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
        rst_n = 1'b1;
        void'(sb_q.pop_back());
        rise_adj = slave_rises - 8 * w_idx;
        v0 = rx_cnt;
        @(negedge clk);
        check("abort_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        repeat (80) @(negedge clk);
        check("abort_no_rx", rx_cnt - v0, 0);

        // tx_valid held across a final byte: next SSEL fall must wait out GAP.
        send(8'hC6, 1'b1, 8'h35, exp_of(8'hC6, 8'h35), 1'b1);
        send(8'h3B, 1'b1, 8'hA1, exp_of(8'h3B, 8'hA1), 1'b0);
        wait_idle();
        check("ssel_gap", last_gap, CLK_DIV + 1);

`ifdef SPI_MASTER_LOOPBACK_EN
        miso_force1 = 1'b1;
        send(8'h5A, 1'b1, 8'h00, 8'h5A, 1'b0);
        wait_idle();
        check("loopback_rx", {24'd0, bus.rx_data}, 32'h5A);
        miso_force1 = 1'b0;
`endif

        check("mosi_zero_when_deselected", mosi_viol, 0);
        check("rx_valid_single_cycle", rxv_wide, 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 4..255.
REQ-002 SHALL have port clk  input  1  system clock; every register updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous to clk, active-low.
REQ-004 SHALL have port tx_data  input  8  byte to send, MSB first.
REQ-005 SHALL have port tx_last  input  1  qualifies tx_data: 1 = final byte of the transaction.
REQ-006 SHALL have port tx_valid  input  1  tx_data/tx_last are valid.
REQ-007 SHALL have port tx_ready  output  1  master accepts a byte in this cycle.
REQ-008 SHALL have port rx_data  output  8  byte captured from MISO.
REQ-009 SHALL have port rx_valid  output  1  one-cycle strobe; rx_data is valid.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have ports SCK, MOSI, SSEL  output  1 each  SPI bus; mode 0 (CPOL=0, CPHA=0); SSEL is active-low.
REQ-012 SHALL have port MISO  input  1  SPI data from the slave.

Function
REQ-013 SHALL implement the states IDLE, SHIFT, WAIT_NEXT, HOLD and GAP.
REQ-014 SHALL drive tx_ready high only in IDLE and WAIT_NEXT; a byte is accepted when tx_valid && tx_ready.
REQ-015 SHALL, on acceptance at cycle T, enter SHIFT with SSEL=0, SCK=0 and MOSI=tx_data[7] at T+1.
REQ-016 SHALL hold SCK low for CLK_DIV cycles, then high for CLK_DIV cycles, for exactly 8 periods per byte.
REQ-017 SHALL shift MISO into the rx shift register on the cycle SCK goes high, MSB first.
REQ-018 SHALL present the next MOSI bit on the cycle SCK goes low; MOSI is held stable while SCK is high.
REQ-019 SHALL, on the 8th SCK falling edge (T+1+16*CLK_DIV), update rx_data and pulse rx_valid for exactly 1 cycle.
REQ-020 SHALL go to WAIT_NEXT after a byte with tx_last=0; SSEL stays 0, SCK stays 0, and the wait is unbounded.
REQ-021 SHALL go to HOLD after a byte with tx_last=1, keep SSEL=0 for CLK_DIV cycles, then set SSEL=1 and enter GAP.
REQ-022 SHALL keep SSEL=1 in GAP for CLK_DIV cycles, then enter IDLE; a transaction is never started during GAP.
REQ-023 SHALL ignore tx_valid outside IDLE and WAIT_NEXT; the input byte is not sampled.
REQ-024 SHALL hold MOSI at 0 whenever SSEL=1.
REQ-025 SHALL use internal divider and bit counters that never wrap mid-byte; the bit count is 0..7 and the divider count is 0..CLK_DIV-1.

Reset
REQ-026 SHALL, while rst_n=0 at a clk edge, set state=IDLE, SSEL=1, SCK=0, MOSI=0, rx_valid=0, rx_data=8'h00 and clear all counters.
REQ-027 SHALL, on reset mid-transfer, abort immediately; the partial byte is discarded and no rx_valid is produced.
REQ-028 SHALL drive tx_ready=1 on the first cycle after rst_n returns high.

Configuration
REQ-029 SHALL, when macro SPI_MASTER_LOOPBACK_EN is defined, sample the internal MOSI in place of the MISO port (MISO ignored), so rx_data equals the byte sent.
REQ-030 SHALL, when SPI_MASTER_LOOPBACK_EN is undefined, sample the MISO port as in REQ-017; all bus timing is identical in both builds.

Verification
REQ-031 SHALL cover: CLK_DIV=4, send 8'hA5 with tx_last=1, slave model returns 8'h3C -> MOSI bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid at T+65; SSEL rises at T+69.
REQ-032 SHALL cover: three bytes 8'h03, 8'h11, 8'hFF, with tx_last on the third -> SSEL low continuously, exactly 24 SCK rising edges, 3 rx_valid pulses.
REQ-033 SHALL cover: tx_valid delayed 20 cycles in WAIT_NEXT -> SCK stays 0, SSEL stays 0, tx_ready=1 throughout.
REQ-034 SHALL cover: rst_n pulsed low after the 4th SCK rising edge -> next cycle SSEL=1, SCK=0, MOSI=0; no rx_valid; tx_ready=1 after release.
REQ-035 SHALL cover: tx_valid held high across a tx_last=1 byte -> next transaction's SSEL fall occurs no earlier than CLK_DIV cycles after the SSEL rise.
REQ-036 SHALL cover: build with SPI_MASTER_LOOPBACK_EN defined, MISO tied to 1, send 8'h5A -> rx_data=8'h5A.
